// File: rtl/amp_window_scheduler.sv
// Windowed ones-counter for a 1-bit digitizer stream: integrates 2^WIN_BITS
// samples per window, compares the count against a threshold and hands the
// result over a valid/ready interface, counting results dropped by backpressure.
module amp_window_scheduler #(
  parameter int unsigned WIN_BITS = 8,
  parameter int unsigned CNT_W    = WIN_BITS + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sig,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] res_data,
  output logic             res_above,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       overrun
);

  typedef enum logic {
    IDLE,
    INTEGRATE
  } state_t;

  state_t              state;
  logic [WIN_BITS-1:0] win_cnt;
  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    final_sum;
  logic                win_end;
  logic                load_ok;

  // final_sum folds in the current sample so the window-end cycle is counted
  always_comb begin
    final_sum = acc + CNT_W'(sig);
    win_end   = (state == INTEGRATE) && (win_cnt == '1);
    load_ok   = !res_valid || res_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      win_cnt   <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_above <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= '0;
    end else begin
      case (state)
        IDLE: begin
          win_cnt <= '0;
          acc     <= '0;
          if (run) begin
            state <= INTEGRATE;
            busy  <= 1'b1;
          end
        end
        INTEGRATE: begin
          if (win_end) begin
            win_cnt <= '0;
            acc     <= '0;
            if (!run) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!run) begin
            win_cnt <= '0;
            acc     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            acc     <= final_sum;
          end
        end
      endcase

      // A transfer on the window-end cycle frees the slot for the new result
      if (win_end) begin
        if (load_ok) begin
          res_data  <= final_sum;
          res_above <= (final_sum >= thresh);
          res_valid <= 1'b1;
        end else if (overrun != 8'hFF) begin
          overrun <= overrun + 8'd1;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
